// File: rtl/ex_operand_stage_if.sv
// ID/EX operand-stage bus: ID capture handshake, MEM/WB forwarding taps, ALU operand outputs.
// The master modport is the pipeline side that drives ID, MEM, WB and EX/MEM ready.
interface ex_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_rs2_val;
  logic [XLEN-1:0] in_imm;
  logic            in_src0_sel;
  logic            in_src1_sel;
  logic [OPW-1:0]  in_alu_op;
  logic [4:0]      in_rd;
  logic            in_rf_we;
  logic            mem_rf_we;
  logic            mem_is_load;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_wd;
  logic            wb_rf_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_wd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_src0;
  logic [XLEN-1:0] alu_src1;
  logic [OPW-1:0]  alu_op;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic            out_rf_we;
  logic [XLEN-1:0] out_rs2_fwd;

  modport master (
    output flush, in_valid, in_pc, in_rs1, in_rs2, in_rs1_val, in_rs2_val, in_imm,
           in_src0_sel, in_src1_sel, in_alu_op, in_rd, in_rf_we,
           mem_rf_we, mem_is_load, mem_rd, mem_wd, wb_rf_we, wb_rd, wb_wd, out_ready,
    input  in_ready, out_valid, alu_src0, alu_src1, alu_op, out_pc, out_rd, out_rf_we, out_rs2_fwd
  );

  modport slave (
    input  flush, in_valid, in_pc, in_rs1, in_rs2, in_rs1_val, in_rs2_val, in_imm,
           in_src0_sel, in_src1_sel, in_alu_op, in_rd, in_rf_we,
           mem_rf_we, mem_is_load, mem_rd, mem_wd, wb_rf_we, wb_rd, wb_wd, out_ready,
    output in_ready, out_valid, alu_src0, alu_src1, alu_op, out_pc, out_rd, out_rf_we, out_rs2_fwd
  );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use bubble and ALU source select.
// Each source operand (rs1, rs2) is handled by one ex_operand_lane instance.
module ex_operand_lane #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      idx_i,
  input  logic [XLEN-1:0] held_i,
  input  logic            use_i,
  input  logic [4:0]      cap_idx_i,
  input  logic [XLEN-1:0] cap_val_i,
  input  logic            mem_we_i,
  input  logic            mem_ld_i,
  input  logic [4:0]      mem_rd_i,
  input  logic [XLEN-1:0] mem_wd_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_wd_i,
  output logic [XLEN-1:0] fwd_o,
  output logic [XLEN-1:0] hold_o,
  output logic [XLEN-1:0] cap_o,
  output logic            haz_o
);
  logic nz, mem_hit, wb_hit, wb_cap_hit;

  assign nz         = (idx_i != 5'd0);
  assign mem_hit    = nz && mem_we_i && (mem_rd_i == idx_i);
  assign wb_hit     = nz && wb_we_i && (wb_rd_i == idx_i);
  assign wb_cap_hit = (cap_idx_i != 5'd0) && wb_we_i && (wb_rd_i == cap_idx_i);

  assign fwd_o  = !nz ? '0 : mem_hit ? mem_wd_i : wb_hit ? wb_wd_i : held_i;
  // Held copy tracks WB every cycle so a stalled instruction never reads stale data.
  assign hold_o = wb_hit ? wb_wd_i : held_i;
  assign cap_o  = wb_cap_hit ? wb_wd_i : cap_val_i;
  // Load data only exists once the load reaches WB; unused operands never stall.
  assign haz_o  = mem_hit && mem_ld_i && use_i;
endmodule

module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input logic            clk,
  input logic            rst,
  ex_operand_stage_if.slave io
);
  localparam int NSRC = 2;

  typedef struct packed {
    logic [XLEN-1:0]            pc;
    logic [NSRC-1:0][4:0]       rs;
    logic [NSRC-1:0][XLEN-1:0]  rv;
    logic [XLEN-1:0]            imm;
    logic [NSRC-1:0]            sel;
    logic [OPW-1:0]             op;
    logic [4:0]                 rd;
    logic                       we;
  } held_t;

  held_t v_unused_guard;
  held_t st_q, st_d;
  logic  v_q, v_d;

  logic [NSRC-1:0][4:0]      in_idx;
  logic [NSRC-1:0][XLEN-1:0] in_val, fwd, hold, cap;
  logic [NSRC-1:0]           haz;
  logic                      hazard, fire_out, capture;

  assign v_unused_guard = st_q;
  assign in_idx = {io.in_rs2, io.in_rs1};
  assign in_val = {io.in_rs2_val, io.in_rs1_val};

  for (genvar g = 0; g < NSRC; g++) begin : g_lane
    ex_operand_lane #(.XLEN(XLEN)) u_lane (
      .idx_i     (st_q.rs[g]),
      .held_i    (st_q.rv[g]),
      .use_i     (!st_q.sel[g]),
      .cap_idx_i (in_idx[g]),
      .cap_val_i (in_val[g]),
      .mem_we_i  (io.mem_rf_we),
      .mem_ld_i  (io.mem_is_load),
      .mem_rd_i  (io.mem_rd),
      .mem_wd_i  (io.mem_wd),
      .wb_we_i   (io.wb_rf_we),
      .wb_rd_i   (io.wb_rd),
      .wb_wd_i   (io.wb_wd),
      .fwd_o     (fwd[g]),
      .hold_o    (hold[g]),
      .cap_o     (cap[g]),
      .haz_o     (haz[g])
    );
  end

  assign hazard       = v_q && (|haz);
  assign io.out_valid = v_q && !hazard;
  assign fire_out     = io.out_valid && io.out_ready;
  assign io.in_ready  = !v_q || fire_out;
  assign capture      = io.in_valid && io.in_ready;

  assign io.alu_src0    = st_q.sel[0] ? st_q.pc  : fwd[0];
  assign io.alu_src1    = st_q.sel[1] ? st_q.imm : fwd[1];
  assign io.alu_op      = st_q.op;
  assign io.out_pc      = st_q.pc;
  assign io.out_rd      = st_q.rd;
  assign io.out_rf_we   = st_q.we;
  assign io.out_rs2_fwd = fwd[1];

  always_comb begin
    v_d     = v_q;
    st_d    = st_q;
    st_d.rv = hold;
    if (io.flush) begin
      v_d = 1'b0;
    end else if (capture) begin
      v_d      = 1'b1;
      st_d.pc  = io.in_pc;
      st_d.rs  = in_idx;
      st_d.rv  = cap;
      st_d.imm = io.in_imm;
      st_d.sel = {io.in_src1_sel, io.in_src0_sel};
      st_d.op  = io.in_alu_op;
      st_d.rd  = io.in_rd;
      st_d.we  = io.in_rf_we;
    end else if (fire_out) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= 1'b0;
      st_q <= '0;
    end else begin
      v_q  <= v_d;
      st_q <= st_d;
    end
  end
endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized + directed bench for ex_operand_stage: the driver predicts each cycle's outputs
// from a transaction-level model and queues them; the monitor pops and compares at negedge.
module tb_ex_operand_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_operand_stage_if #(.XLEN(32), .OPW(5)) ifc ();
  ex_operand_stage #(.XLEN(32), .OPW(5)) dut (.clk(clk), .rst(rst), .io(ifc));

  typedef struct {
    bit          rst, flush, in_valid, s0, s1, we, mwe, mld, wwe, ordy;
    logic [31:0] pc, v1, v2, imm, mwd, wwd;
    logic [4:0]  rs1, rs2, op, rd, mrd, wrd;
  } stim_t;

  typedef struct {
    bit          ov, ir, we;
    logic [31:0] s0, s1, pc, r2f;
    logic [4:0]  op, rd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model of the instruction held in EX: latest known architectural value of each source.
  bit          mv;
  logic [31:0] m_pc, m_imm;
  logic [4:0]  m_rs[2];
  logic [31:0] m_r[2];
  bit          m_sel[2];
  logic [4:0]  m_op, m_rd;
  bit          m_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.ordy = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] newest(input logic [4:0] idx, input logic [31:0] old, input stim_t s,
                                        input bit with_mem);
    if (idx == 5'd0) return 32'h0;
    if (with_mem && s.mwe && s.mrd == idx) return s.mwd;
    if (s.wwe && s.wrd == idx) return s.wwd;
    return old;
  endfunction

  task automatic step(input stim_t s);
    exp_t        e;
    logic [31:0] f[2];
    bit          haz, fire;
    @(posedge clk);
    #1;
    rst = s.rst;
    ifc.flush = s.flush;        ifc.in_valid = s.in_valid;   ifc.in_pc = s.pc;
    ifc.in_rs1 = s.rs1;         ifc.in_rs2 = s.rs2;          ifc.in_rs1_val = s.v1;
    ifc.in_rs2_val = s.v2;      ifc.in_imm = s.imm;          ifc.in_src0_sel = s.s0;
    ifc.in_src1_sel = s.s1;     ifc.in_alu_op = s.op;        ifc.in_rd = s.rd;
    ifc.in_rf_we = s.we;        ifc.mem_rf_we = s.mwe;       ifc.mem_is_load = s.mld;
    ifc.mem_rd = s.mrd;         ifc.mem_wd = s.mwd;          ifc.wb_rf_we = s.wwe;
    ifc.wb_rd = s.wrd;          ifc.wb_wd = s.wwd;           ifc.out_ready = s.ordy;

    haz = 1'b0;
    for (int k = 0; k < 2; k++) begin
      f[k] = newest(m_rs[k], m_r[k], s, 1'b1);
      if (mv && !m_sel[k] && m_rs[k] != 5'd0 && s.mwe && s.mld && s.mrd == m_rs[k]) haz = 1'b1;
    end
    e.ov  = mv && !haz;
    fire  = e.ov && s.ordy;
    e.ir  = !mv || fire;
    e.s0  = m_sel[0] ? m_pc : f[0];
    e.s1  = m_sel[1] ? m_imm : f[1];
    e.r2f = f[1];
    e.op  = m_op;  e.pc = m_pc;  e.rd = m_rd;  e.we = m_we;
    q.push_back(e);

    if (s.rst) begin
      mv = 0; m_pc = 0; m_imm = 0; m_op = 0; m_rd = 0; m_we = 0;
      for (int k = 0; k < 2; k++) begin m_rs[k] = 0; m_r[k] = 0; m_sel[k] = 0; end
    end else if (s.flush) begin
      mv = 0;
    end else if (s.in_valid && e.ir) begin
      mv = 1; m_pc = s.pc; m_imm = s.imm; m_op = s.op; m_rd = s.rd; m_we = s.we;
      m_rs[0] = s.rs1; m_rs[1] = s.rs2; m_sel[0] = s.s0; m_sel[1] = s.s1;
      m_r[0] = (s.rs1 == 5'd0) ? s.v1 : newest(s.rs1, s.v1, s, 1'b0);
      m_r[1] = (s.rs2 == 5'd0) ? s.v2 : newest(s.rs2, s.v2, s, 1'b0);
    end else begin
      if (fire) mv = 0;
      for (int k = 0; k < 2; k++)
        if (m_rs[k] != 5'd0) m_r[k] = newest(m_rs[k], m_r[k], s, 1'b0);
    end
  endtask

  function automatic stim_t rnd();
    stim_t s;
    s.rst = ($urandom_range(99) == 0);  s.flush = ($urandom_range(19) == 0);
    s.in_valid = ($urandom_range(9) < 7); s.ordy = ($urandom_range(9) < 7);
    s.pc = $urandom; s.imm = $urandom; s.v1 = $urandom; s.v2 = $urandom;
    s.rs1 = 5'($urandom_range(3)); s.rs2 = 5'($urandom_range(3));
    s.s0 = $urandom_range(1); s.s1 = $urandom_range(1);
    s.op = 5'($urandom); s.rd = 5'($urandom); s.we = $urandom_range(1);
    s.mwe = $urandom_range(1); s.mld = $urandom_range(1);
    s.mrd = 5'($urandom_range(3)); s.mwd = $urandom;
    s.wwe = $urandom_range(1); s.wrd = 5'($urandom_range(3)); s.wwd = $urandom;
    return s;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_valid", 32'(ifc.out_valid), 32'(e.ov));
        chk("in_ready", 32'(ifc.in_ready), 32'(e.ir));
        if (e.ov) begin
          chk("alu_src0", ifc.alu_src0, e.s0);
          chk("alu_src1", ifc.alu_src1, e.s1);
          chk("alu_op", 32'(ifc.alu_op), 32'(e.op));
          chk("out_pc", ifc.out_pc, e.pc);
          chk("out_rd", 32'(ifc.out_rd), 32'(e.rd));
          chk("out_rf_we", 32'(ifc.out_rf_we), 32'(e.we));
          chk("out_rs2_fwd", ifc.out_rs2_fwd, e.r2f);
        end
      end
    end
  end

  initial begin : driver
    stim_t s;
    mv = 0; m_pc = 0; m_imm = 0; m_op = 0; m_rd = 0; m_we = 0;
    for (int k = 0; k < 2; k++) begin m_rs[k] = 0; m_r[k] = 0; m_sel[k] = 0; end
    s = idle();
    rst = 1'b1;
    ifc.flush = 0; ifc.in_valid = 0; ifc.in_pc = 0; ifc.in_rs1 = 0; ifc.in_rs2 = 0;
    ifc.in_rs1_val = 0; ifc.in_rs2_val = 0; ifc.in_imm = 0; ifc.in_src0_sel = 0;
    ifc.in_src1_sel = 0; ifc.in_alu_op = 0; ifc.in_rd = 0; ifc.in_rf_we = 0;
    ifc.mem_rf_we = 0; ifc.mem_is_load = 0; ifc.mem_rd = 0; ifc.mem_wd = 0;
    ifc.wb_rf_we = 0; ifc.wb_rd = 0; ifc.wb_wd = 0; ifc.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_alu_src0", ifc.alu_src0, 32'd0);
    chk("rst_alu_src1", ifc.alu_src1, 32'd0);
    chk("rst_alu_op", 32'(ifc.alu_op), 32'd0);

    // basic add
    s = idle(); s.in_valid = 1; s.rs1 = 1; s.v1 = 5; s.rs2 = 2; s.v2 = 7; s.rd = 5; s.we = 1;
    step(s); step(idle());
    // MEM beats WB, then x0 never forwards
    s = idle(); s.in_valid = 1; s.rs1 = 3; s.v1 = 1; step(s);
    s = idle(); s.ordy = 0; s.mwe = 1; s.mrd = 3; s.mwd = 32'h10; s.wwe = 1; s.wrd = 3; s.wwd = 32'h20;
    step(s); step(idle());
    s = idle(); s.in_valid = 1; s.rs1 = 0; s.v1 = 32'h55; step(s);
    s = idle(); s.mwe = 1; s.mrd = 0; s.mwd = 32'h99; step(s);
    // load-use bubble then WB resolve
    s = idle(); s.in_valid = 1; s.rs2 = 4; s.v2 = 32'h11; step(s);
    s = idle(); s.mwe = 1; s.mld = 1; s.mrd = 4; s.mwd = 32'hDEAD; step(s);
    s = idle(); s.wwe = 1; s.wrd = 4; s.wwd = 32'hABCD; step(s);
    // stall three cycles, then flush with a competing incoming instruction
    s = idle(); s.in_valid = 1; s.rs1 = 1; s.v1 = 9; s.op = 5'h3; step(s);
    s = idle(); s.ordy = 0; s.in_valid = 1; s.rs1 = 2; repeat (3) step(s);
    s.flush = 1; step(s);
    step(idle());
    // pc/imm source select, store data still forwarded
    s = idle(); s.in_valid = 1; s.s0 = 1; s.s1 = 1; s.pc = 32'h80; s.imm = 32'hFFFFFFFC;
    s.rs2 = 2; s.v2 = 32'h33; step(s);
    step(idle());
    // reset while holding
    s = idle(); s.in_valid = 1; s.rs1 = 1; s.v1 = 32'h77; step(s);
    s = idle(); s.ordy = 0; step(s);
    s.rst = 1; step(s);
    step(idle());

    for (int i = 0; i < 3000; i++) step(rnd());
    step(idle());
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
